sevseg_capture: RTL and testbench

Receive-side counterpart of the multiplexed seven-segment display driver. It samples the four-digit scan and segment outputs (`scan`, `decoder_out`) and rebuilds the four displayed BCD digits, one settled capture per digit dwell. When a complete four-digit frame is assembled, it publishes the frame with a one-cycle strobe. It is used for on-board self-check and for bench observation of the clock, alarm and stopwatch display paths.

---
 rtl/sevseg_capture.sv | 196 +++++++++++++++++++
 tb/tb_sevseg_capture.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_capture.sv
// rtl/sevseg_capture.sv - rebuilds displayed BCD digits from a multiplexed seven-segment scan
module sevseg_capture #(
    parameter int SETTLE          = 4,
    parameter int TIMEOUT         = 1024,
    parameter bit SCAN_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] scan,
    input  logic [6:0] seg,
    output logic [3:0] right_one,
    output logic [3:0] right_ten,
    output logic [3:0] left_one,
    output logic [3:0] left_ten,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       frame_changed,
    output logic       stalled
);
    localparam logic [3:0]  SCAN_INV    = SCAN_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0]  SEG_INV     = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]  SETTLE_CNT  = 4'(SETTLE);
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

    state_t      state, state_n;
    logic [3:0]  scan_q, scan_p;
    logic [6:0]  seg_q, seg_p;
    logic [3:0]  cnt, cnt_n;
    logic [3:0]  seen, seen_n, inv, inv_n;
    logic [3:0]  slot   [4];
    logic [3:0]  slot_n [4];
    logic [15:0] tcnt, tcnt_n;
    logic [3:0]  scan_n;
    logic [6:0]  seg_n;
    logic        scan_legal, scan_changed, any_changed;
    logic        capture, frame_done, timed_out, digits_differ;
    logic [1:0]  sel;
    logic        dec_ok;
    logic [3:0]  dec_digit;

    assign scan_n       = scan_q ^ SCAN_INV;
    assign seg_n        = seg_q ^ SEG_INV;
    assign scan_legal   = (scan_n != 4'b0) && ((scan_n & (scan_n - 4'd1)) == 4'b0);
    assign scan_changed = (scan_q != scan_p);
    assign any_changed  = scan_changed || (seg_q != seg_p);

    always_comb begin
        dec_ok    = 1'b1;
        dec_digit = 4'd0;
        case (seg_n)
            7'h3F:   dec_digit = 4'd0;
            7'h06:   dec_digit = 4'd1;
            7'h5B:   dec_digit = 4'd2;
            7'h4F:   dec_digit = 4'd3;
            7'h66:   dec_digit = 4'd4;
            7'h6D:   dec_digit = 4'd5;
            7'h7D:   dec_digit = 4'd6;
            7'h07:   dec_digit = 4'd7;
            7'h7F:   dec_digit = 4'd8;
            7'h6F:   dec_digit = 4'd9;
            default: dec_ok    = 1'b0;
        endcase
    end

    always_comb begin
        case (scan_n)
            4'b0010: sel = 2'd1;
            4'b0100: sel = 2'd2;
            4'b1000: sel = 2'd3;
            default: sel = 2'd0;
        endcase
    end

    // Dwell tracking: cnt_n is the length of the current stable run of scan_q/seg_q.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (scan_legal) begin
                    state_n = ST_SETTLE;
                    cnt_n   = 4'd1;
                end
            end
            ST_SETTLE: begin
                if (!scan_legal) begin
                    state_n = ST_IDLE;
                    cnt_n   = 4'd0;
                end else if (any_changed) begin
                    cnt_n = 4'd1;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            ST_HOLD: begin
                if (!scan_legal) begin
                    state_n = ST_IDLE;
                    cnt_n   = 4'd0;
                end else if (scan_changed) begin
                    state_n = ST_SETTLE;
                    cnt_n   = 4'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
        if (state_n == ST_SETTLE && cnt_n == SETTLE_CNT) begin
            capture = 1'b1;
            state_n = ST_HOLD;
        end
    end

    always_comb begin
        seen_n = seen;
        inv_n  = inv;
        for (int i = 0; i < 4; i++) slot_n[i] = slot[i];
        if (capture) begin
            seen_n[sel] = 1'b1;
            inv_n[sel]  = !dec_ok;
            slot_n[sel] = dec_digit;
        end
        frame_done    = capture && (seen_n == 4'hF);
        digits_differ = {slot_n[3], slot_n[2], slot_n[1], slot_n[0]} !=
                        {left_ten, left_one, right_ten, right_one};
        if (capture)
            tcnt_n = 16'd0;
        else if (tcnt == TIMEOUT_CNT)
            tcnt_n = tcnt;
        else
            tcnt_n = tcnt + 16'd1;
        timed_out = (tcnt_n == TIMEOUT_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= 4'd0;
            scan_q        <= SCAN_INV;
            scan_p        <= SCAN_INV;
            seg_q         <= SEG_INV;
            seg_p         <= SEG_INV;
            seen          <= 4'b0;
            inv           <= 4'b0;
            tcnt          <= 16'd0;
            for (int i = 0; i < 4; i++) slot[i] <= 4'd0;
            right_one     <= 4'd0;
            right_ten     <= 4'd0;
            left_one      <= 4'd0;
            left_ten      <= 4'd0;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            frame_changed <= 1'b0;
            stalled       <= 1'b0;
        end else begin
            scan_q        <= scan;
            scan_p        <= scan_q;
            seg_q         <= seg;
            seg_p         <= seg_q;
            state         <= state_n;
            cnt           <= cnt_n;
            tcnt          <= tcnt_n;
            stalled       <= timed_out;
            for (int i = 0; i < 4; i++) slot[i] <= slot_n[i];
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
            frame_changed <= 1'b0;
            if (frame_done) begin
                seen <= 4'b0;
                inv  <= 4'b0;
                if (inv_n == 4'b0) begin
                    right_one     <= slot_n[0];
                    right_ten     <= slot_n[1];
                    left_one      <= slot_n[2];
                    left_ten      <= slot_n[3];
                    frame_valid   <= 1'b1;
                    frame_changed <= digits_differ;
                end else begin
                    frame_err <= 1'b1;
                end
            end else if (timed_out) begin
                // Stalled scan: drop whatever partial frame was collected.
                seen <= 4'b0;
                inv  <= 4'b0;
            end else begin
                seen <= seen_n;
                inv  <= inv_n;
            end
        end
    end
endmodule

// File: tb/tb_sevseg_capture.sv
// tb/tb_sevseg_capture.sv - randomized self-checking bench for sevseg_capture
module tb_sevseg_capture;
    localparam int S  = 4;
    localparam int TO = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] scan;
    logic [6:0] seg;
    logic [3:0] right_one, right_ten, left_one, left_ten;
    logic       frame_valid, frame_err, frame_changed, stalled;

    always #5 clk = ~clk;

    sevseg_capture #(.SETTLE(S), .TIMEOUT(TO), .SCAN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .scan(scan), .seg(seg),
        .right_one(right_one), .right_ten(right_ten), .left_one(left_one), .left_ten(left_ten),
        .frame_valid(frame_valid), .frame_err(frame_err), .frame_changed(frame_changed),
        .stalled(stalled)
    );

    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int n_checks = 0, n_pass = 0;
    int cyc = 0, trace_err = 0, excl_err = 0;
    int fv_cnt = 0, fe_cnt = 0, fc_cnt = 0, fv_at = 0;
    bit prev_pulse = 1'b0;

    logic [3:0] m_slot [4];
    logic [3:0] m_out  [4];
    bit         m_seen [4];
    bit         m_inv  [4];
    bit         m_fv, m_fe, m_fc, m_st;
    int         m_tcnt, m_fv_total = 0, run;
    logic [3:0] last_s;
    logic [6:0] last_g;

    function automatic int seg_digit(input logic [6:0] lit);
        for (int i = 0; i < 10; i++) if (pat[i] == lit) return i;
        return -1;
    endfunction

    function automatic int scan_slot(input logic [3:0] s);
        int zeros = 0, pos = -1;
        for (int i = 0; i < 4; i++) if (!s[i]) begin zeros++; pos = i; end
        return (zeros == 1) ? pos : -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_slot[i] = 4'd0; m_out[i] = 4'd0; m_seen[i] = 1'b0; m_inv[i] = 1'b0;
        end
        m_fv = 0; m_fe = 0; m_fc = 0; m_st = 0; m_tcnt = 0;
        run = 0; last_s = 4'hF; last_g = 7'h7F;
    endtask

    // A digit is taken once per dwell, at the end of the cycle after its S-th constant input cycle.
    task automatic model_step(input logic [3:0] s, input logic [6:0] g);
        int k, d;
        bit all_seen, any_inv;
        m_fv = 0; m_fe = 0; m_fc = 0;
        if (rst) begin model_reset(); return; end
        k = scan_slot(last_s);
        if (k >= 0 && run == S) begin
            d = seg_digit(~last_g);
            m_slot[k] = (d < 0) ? 4'd0 : 4'(d);
            m_seen[k] = 1'b1;
            m_inv[k]  = (d < 0);
            m_tcnt = 0; m_st = 0;
            all_seen = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
            any_inv  = m_inv[0] || m_inv[1] || m_inv[2] || m_inv[3];
            if (all_seen) begin
                if (!any_inv) begin
                    for (int i = 0; i < 4; i++) begin
                        if (m_slot[i] != m_out[i]) m_fc = 1;
                        m_out[i] = m_slot[i];
                    end
                    m_fv = 1; m_fv_total++;
                end else begin
                    m_fe = 1;
                end
                for (int i = 0; i < 4; i++) begin m_seen[i] = 0; m_inv[i] = 0; end
            end
        end else begin
            if (m_tcnt < TO) m_tcnt++;
            if (m_tcnt == TO) begin
                m_st = 1;
                for (int i = 0; i < 4; i++) begin m_seen[i] = 0; m_inv[i] = 0; end
            end
        end
        if (s === last_s && g === last_g) run++; else run = 1;
        last_s = s; last_g = g;
    endtask

    task automatic tick(input logic [3:0] s, input logic [6:0] g);
        scan = s; seg = g;
        @(posedge clk);
        model_step(s, g);
        @(negedge clk);
        if ({left_ten, left_one, right_ten, right_one} !== {m_out[3], m_out[2], m_out[1], m_out[0]} ||
            {frame_valid, frame_err, frame_changed, stalled} !== {m_fv, m_fe, m_fc, m_st})
            trace_err++;
        if (frame_valid && frame_err) excl_err++;
        if ((frame_valid || frame_err) && prev_pulse) excl_err++;
        prev_pulse = frame_valid || frame_err;
        if (frame_valid) begin fv_cnt++; fv_at = cyc + 1; end
        if (frame_err) fe_cnt++;
        if (frame_changed) fc_cnt++;
        cyc++;
    endtask

    task automatic dwell(input int slot, input logic [6:0] lit, input int len);
        logic [3:0] one = 4'b0001;
        logic [3:0] s;
        s = (slot < 0) ? 4'hF : ~(one << slot[1:0]);
        repeat (len) tick(s, ~lit);
    endtask

    task automatic full_pass(input int d0, input int d1, input int d2, input int d3, input int len);
        dwell(0, pat[d0], len);
        dwell(1, pat[d1], len);
        dwell(2, pat[d2], len);
        dwell(3, pat[d3], len);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick(4'hF, 7'h7F);
        n_checks++;
        if ({left_ten, left_one, right_ten, right_one} !== 16'h0)
            $display("FAIL reset_digits got %h want 0000", {left_ten, left_one, right_ten, right_one});
        else n_pass++;
        n_checks++;
        if ({frame_valid, frame_err, frame_changed, stalled} !== 4'b0)
            $display("FAIL reset_flags got %b want 0000", {frame_valid, frame_err, frame_changed, stalled});
        else n_pass++;
        rst = 1'b0;
        repeat (2) tick(4'hF, 7'h7F);
    endtask

    task automatic test_normal_frame();
        int fv0 = fv_cnt, fc0 = fc_cnt, te0 = trace_err, t;
        dwell(0, pat[3], 10);
        dwell(1, pat[4], 10);
        dwell(2, pat[1], 10);
        t = cyc;
        dwell(3, pat[2], 10);
        n_checks++;
        if ({left_ten, left_one, right_ten, right_one} !== 16'h2143)
            $display("FAIL normal_digits got %h want 2143", {left_ten, left_one, right_ten, right_one});
        else n_pass++;
        n_checks++;
        if (fv_cnt - fv0 !== 1) $display("FAIL normal_valid_count got %0d want 1", fv_cnt - fv0); else n_pass++;
        n_checks++;
        if (fc_cnt - fc0 !== 1) $display("FAIL normal_changed_count got %0d want 1", fc_cnt - fc0); else n_pass++;
        n_checks++;
        if (fv_at - t !== S + 1) $display("FAIL normal_latency got %0d want %0d", fv_at - t, S + 1); else n_pass++;
        n_checks++;
        if (trace_err - te0 !== 0) $display("FAIL normal_trace got %0d bad cycles want 0", trace_err - te0); else n_pass++;
    endtask

    task automatic test_repeat();
        int fv0 = fv_cnt, fc0 = fc_cnt;
        full_pass(3, 4, 1, 2, 10);
        n_checks++;
        if (fv_cnt - fv0 !== 1) $display("FAIL repeat_valid_count got %0d want 1", fv_cnt - fv0); else n_pass++;
        n_checks++;
        if (fc_cnt - fc0 !== 0) $display("FAIL repeat_changed_count got %0d want 0", fc_cnt - fc0); else n_pass++;
    endtask

    task automatic test_glitch();
        int fv0 = fv_cnt, fe0 = fe_cnt, te0 = trace_err;
        dwell(0, pat[5], 10);
        dwell(1, pat[7], 3);
        dwell(2, pat[6], 10);
        dwell(3, pat[0], 10);
        n_checks++;
        if (fv_cnt - fv0 !== 0) $display("FAIL glitch_early_valid got %0d want 0", fv_cnt - fv0); else n_pass++;
        dwell(1, pat[9], 10);
        n_checks++;
        if (fv_cnt - fv0 !== 1) $display("FAIL glitch_valid_count got %0d want 1", fv_cnt - fv0); else n_pass++;
        n_checks++;
        if ({left_ten, left_one, right_ten, right_one} !== 16'h0695)
            $display("FAIL glitch_digits got %h want 0695", {left_ten, left_one, right_ten, right_one});
        else n_pass++;
        n_checks++;
        if (fe_cnt - fe0 !== 0) $display("FAIL glitch_err_count got %0d want 0", fe_cnt - fe0); else n_pass++;
        n_checks++;
        if (trace_err - te0 !== 0) $display("FAIL glitch_trace got %0d bad cycles want 0", trace_err - te0); else n_pass++;
    endtask

    task automatic test_invalid();
        int fv0 = fv_cnt, fe0 = fe_cnt;
        dwell(0, pat[1], 10);
        dwell(1, pat[1], 10);
        dwell(2, pat[1], 10);
        dwell(3, 7'h00, 10);
        n_checks++;
        if (fe_cnt - fe0 !== 1) $display("FAIL invalid_err_count got %0d want 1", fe_cnt - fe0); else n_pass++;
        n_checks++;
        if (fv_cnt - fv0 !== 0) $display("FAIL invalid_valid_count got %0d want 0", fv_cnt - fv0); else n_pass++;
        n_checks++;
        if ({left_ten, left_one, right_ten, right_one} !== 16'h0695)
            $display("FAIL invalid_digits got %h want 0695", {left_ten, left_one, right_ten, right_one});
        else n_pass++;
    endtask

    task automatic test_stall();
        int fv0 = fv_cnt, te0 = trace_err;
        dwell(0, pat[1], 10);
        dwell(1, pat[2], 10);
        repeat (TO + 5) tick(4'hF, 7'h7F);
        n_checks++;
        if (stalled !== 1'b1) $display("FAIL stall_level got %b want 1", stalled); else n_pass++;
        dwell(2, pat[7], 10);
        dwell(3, pat[8], 10);
        n_checks++;
        if (fv_cnt - fv0 !== 0) $display("FAIL stall_discard got %0d frames want 0", fv_cnt - fv0); else n_pass++;
        n_checks++;
        if (stalled !== 1'b0) $display("FAIL stall_clear got %b want 0", stalled); else n_pass++;
        full_pass(1, 2, 7, 8, 10);
        n_checks++;
        if (fv_cnt - fv0 !== 1) $display("FAIL stall_recover_count got %0d want 1", fv_cnt - fv0); else n_pass++;
        n_checks++;
        if ({left_ten, left_one, right_ten, right_one} !== 16'h8721)
            $display("FAIL stall_digits got %h want 8721", {left_ten, left_one, right_ten, right_one});
        else n_pass++;
        n_checks++;
        if (trace_err - te0 !== 0) $display("FAIL stall_trace got %0d bad cycles want 0", trace_err - te0); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int fv0, fe0 = fe_cnt, fc0;
        dwell(0, pat[4], 10);
        dwell(1, pat[4], 10);
        dwell(2, pat[4], 10);
        fv0 = fv_cnt;
        rst = 1'b1;
        repeat (2) tick(4'hF, 7'h7F);
        rst = 1'b0;
        n_checks++;
        if ({left_ten, left_one, right_ten, right_one, stalled} !== 17'h0)
            $display("FAIL midreset_outputs got %h want 00000", {left_ten, left_one, right_ten, right_one, stalled});
        else n_pass++;
        n_checks++;
        if (fv_cnt - fv0 + fe_cnt - fe0 !== 0)
            $display("FAIL midreset_pulses got %0d want 0", fv_cnt - fv0 + fe_cnt - fe0);
        else n_pass++;
        fc0 = fc_cnt;
        full_pass(9, 8, 7, 6, 10);
        n_checks++;
        if (fv_cnt - fv0 !== 1) $display("FAIL midreset_valid_count got %0d want 1", fv_cnt - fv0); else n_pass++;
        n_checks++;
        if (fc_cnt - fc0 !== 1) $display("FAIL midreset_changed_count got %0d want 1", fc_cnt - fc0); else n_pass++;
        n_checks++;
        if ({left_ten, left_one, right_ten, right_one} !== 16'h6789)
            $display("FAIL midreset_digits got %h want 6789", {left_ten, left_one, right_ten, right_one});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int te0 = trace_err, fv0 = fv_cnt, mfv0 = m_fv_total;
        int prev_slot = 3, slot, len;
        logic [3:0] s;
        logic [6:0] lit;
        for (int n = 0; n < 250; n++) begin
            len = $urandom_range(1, 11);
            if (len >= S) len++;
            if ($urandom_range(0, 9) < 2) begin
                do s = 4'($urandom_range(0, 15)); while (scan_slot(s) >= 0);
                repeat (len) tick(s, 7'($urandom_range(0, 127)));
                prev_slot = -1;
            end else begin
                do slot = $urandom_range(0, 3); while (slot == prev_slot);
                if ($urandom_range(0, 9) == 0) lit = 7'($urandom_range(0, 127));
                else lit = pat[$urandom_range(0, 9)];
                dwell(slot, lit, len);
                prev_slot = slot;
            end
        end
        n_checks++;
        if (trace_err - te0 !== 0) $display("FAIL random_trace got %0d bad cycles want 0", trace_err - te0); else n_pass++;
        n_checks++;
        if (fv_cnt - fv0 !== m_fv_total - mfv0)
            $display("FAIL random_valid_count got %0d want %0d", fv_cnt - fv0, m_fv_total - mfv0);
        else n_pass++;
        n_checks++;
        if ({left_ten, left_one, right_ten, right_one} !== {m_out[3], m_out[2], m_out[1], m_out[0]})
            $display("FAIL random_digits got %h want %h", {left_ten, left_one, right_ten, right_one},
                     {m_out[3], m_out[2], m_out[1], m_out[0]});
        else n_pass++;
        n_checks++;
        if (excl_err !== 0) $display("FAIL pulse_exclusion got %0d violations want 0", excl_err); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; scan = 4'hF; seg = 7'h7F;
        model_reset();
        test_reset();
        test_normal_frame();
        test_repeat();
        test_glitch();
        test_invalid();
        test_stall();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
